// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encoding, supported
// opcodes and ALU operation codes.
package ctrl_pkg;

  // IDLE must encode as 3'b000 so state_o reads zero while reset is held.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StError  = 3'd6
  } state_e;

  localparam logic [5:0] OpcodeR    = 6'b000000;
  localparam logic [5:0] OpcodeAddi = 6'b001000;
  localparam logic [5:0] OpcodeLw   = 6'b100011;
  localparam logic [5:0] OpcodeSw   = 6'b101011;
  localparam logic [5:0] OpcodeBeq  = 6'b000100;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  function automatic logic is_supported_op(logic [5:0] op);
    return op inside {OpcodeR, OpcodeAddi, OpcodeLw, OpcodeSw, OpcodeBeq};
  endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// wait_timer: counts consecutive memory-stall cycles and flags a timeout.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   active_i     : controller is in a memory phase (FETCH or MEM)
//   ready_i      : memory access-complete strobe
//   timeout_o    : this is the WAIT_MAX-th consecutive stall cycle
module wait_timer
  import ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int unsigned CntW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic            w_stall;

  assign w_stall = active_i & ~ready_i;

  // Clearing whenever not stalling means every entry into FETCH or MEM starts
  // at zero: the cycle before an entry is always either outside a memory phase
  // or the ready cycle that ends one.
  assign w_cnt_d   = w_stall ? r_cnt + 1'b1 : '0;
  assign timeout_o = w_stall && (r_cnt == CntW'(WAIT_MAX - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM controller for a five-instruction multicycle datapath
// (R-type, addi, lw, sw, beq).
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   start_i                   : run enable, sampled at instruction boundaries
//   opcode_i                  : IR[31:26], latched during DECODE
//   mem_ready_i               : memory complete, only observed in FETCH/MEM
//   *_write_o, mem_*_o, ...   : datapath control strobes
//   retire_o                  : one-cycle pulse in an instruction's last cycle
//   busy_o, err_o, state_o    : status
//   instr_cnt_o, cycle_cnt_o  : performance counters
// Build option: define MULTICYCLE_CTRL_PERF_CNT_EN to implement the counters;
// otherwise they read as zero and no counter flops are built.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [5:0]  opcode_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        ir_write_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        reg_dst_o,
  output logic        alu_src_o,
  output logic        mem_to_reg_o,
  output logic        branch_o,
  output logic        retire_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [1:0]  alu_op_o,
  output logic [2:0]  state_o,
  output logic [31:0] instr_cnt_o,
  output logic [31:0] cycle_cnt_o
);

  state_e     r_state;
  state_e     w_state_d;
  logic [5:0] r_opcode;
  logic       w_mem_phase;
  logic       w_timeout;
  logic       w_done;

  assign w_mem_phase = (r_state == StFetch) || (r_state == StMem);
  assign state_o     = r_state;

  wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .active_i  (w_mem_phase),
    .ready_i   (mem_ready_i),
    .timeout_o (w_timeout)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= StIdle;
      r_opcode <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StDecode) begin
        r_opcode <= opcode_i;
      end
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_done       = 1'b0;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    alu_src_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    branch_o     = 1'b0;
    busy_o       = 1'b0;
    err_o        = 1'b0;
    alu_op_o     = AluOpAdd;

    case (r_state)
      StIdle: begin
        if (start_i) w_state_d = StFetch;
      end
      StFetch: begin
        busy_o     = 1'b1;
        mem_read_o = 1'b1;
        // IR and PC capture only on the beat the memory returns data, so a
        // stalled fetch never advances the PC more than once.
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          w_state_d  = StDecode;
        end else if (w_timeout) begin
          w_state_d = StError;
        end
      end
      StDecode: begin
        busy_o    = 1'b1;
        w_state_d = is_supported_op(opcode_i) ? StExec : StError;
      end
      StExec: begin
        busy_o = 1'b1;
        case (r_opcode)
          OpcodeR: begin
            alu_op_o  = AluOpFunct;
            w_state_d = StWb;
          end
          OpcodeAddi: begin
            alu_src_o = 1'b1;
            w_state_d = StWb;
          end
          OpcodeLw, OpcodeSw: begin
            alu_src_o = 1'b1;
            w_state_d = StMem;
          end
          OpcodeBeq: begin
            alu_op_o = AluOpSub;
            branch_o = 1'b1;
            w_done   = 1'b1;
          end
          default: w_state_d = StError;
        endcase
      end
      StMem: begin
        busy_o      = 1'b1;
        mem_read_o  = (r_opcode == OpcodeLw);
        mem_write_o = (r_opcode == OpcodeSw);
        if (mem_ready_i) begin
          if (r_opcode == OpcodeLw) w_state_d = StWb;
          else                      w_done    = 1'b1;
        end else if (w_timeout) begin
          w_state_d = StError;
        end
      end
      StWb: begin
        busy_o       = 1'b1;
        reg_write_o  = 1'b1;
        reg_dst_o    = (r_opcode == OpcodeR);
        mem_to_reg_o = (r_opcode == OpcodeLw);
        w_done       = 1'b1;
      end
      StError: begin
        err_o = 1'b1;
      end
      default: w_state_d = StError;
    endcase

    // start_i is only consulted at completion, so dropping it mid-instruction
    // lets the current instruction finish before parking in IDLE.
    if (w_done) w_state_d = start_i ? StFetch : StIdle;
    retire_o = w_done;
  end

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [31:0] r_instr_cnt;
  logic [31:0] r_cycle_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_instr_cnt <= '0;
      r_cycle_cnt <= '0;
    end else begin
      if (retire_o) r_instr_cnt <= r_instr_cnt + 32'd1;
      if (busy_o)   r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end
  end

  assign instr_cnt_o = r_instr_cnt;
  assign cycle_cnt_o = r_cycle_cnt;
`else
  assign instr_cnt_o = '0;
  assign cycle_cnt_o = '0;
`endif

endmodule
